// File: rtl/router_vc_rr_pkg.sv
// Shared constants for the multi-FIFO mesh router: port indices, default
// widths and the drop-counter width, plus the round-robin pointer helper.
package router_vc_rr_pkg;

  localparam int PORT_N = 0;
  localparam int PORT_S = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  localparam int SIZE_DEF  = 8;
  localparam int DIR_W_DEF = 3;
  localparam int DROP_W    = 16;

  // Arbiter pointer moves to the slot just after the winner.
  function automatic int rr_next(input int g, input int n);
    return (g + 1) % n;
  endfunction

endpackage

// File: rtl/router_fifo_p.sv
// Per-input synchronous FIFO with async active-low reset. Pointers carry one
// extra wrap bit so full and empty are told apart without a counter.
module router_fifo_p #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [SIZE-1:0] wdata,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output logic [SIZE-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [SIZE-1:0] mem_q [DEPTH];

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/router_vc_rr.sv
// Mesh router top: one FIFO per input, external route lookup on each head,
// and a round-robin arbiter per output feeding a one-flit output register.
module router_vc_rr
  import router_vc_rr_pkg::*;
#(
  parameter int ID     = -1,
  parameter int NPORTS = 5,
  parameter int SIZE   = SIZE_DEF,
  parameter int DEPTH  = 4,
  parameter int DIR_W  = DIR_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORTS-1:0]       rx_req,
  output logic [NPORTS-1:0]       rx_ack,
  input  logic [NPORTS*SIZE-1:0]  rx_data,
  output logic [NPORTS-1:0]       tx_req,
  input  logic [NPORTS-1:0]       tx_ack,
  output logic [NPORTS*SIZE-1:0]  tx_data,
  output logic [NPORTS*SIZE-1:0]  table_addr,
  input  logic [NPORTS*DIR_W-1:0] table_data,
  output logic [DROP_W-1:0]       drop_count
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [DIR_W-1:0] NP_DIR = DIR_W'(NPORTS);

  if ((2 ** DIR_W) <= NPORTS || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_err
    $error("router %0d: DIR_W too narrow or DEPTH not a power of two >= 2", ID);
  end

  logic [NPORTS-1:0]             full, empty, push, pop, drop;
  logic [SIZE-1:0]               head [NPORTS];
  logic [DIR_W-1:0]              dest [NPORTS];
  logic [NPORTS-1:0]             gnt_vld;
  logic [PW-1:0]                 gnt_idx [NPORTS];

  logic [NPORTS-1:0]             tx_req_q, tx_req_d;
  logic [NPORTS-1:0][SIZE-1:0]   tx_data_q, tx_data_d;
  logic [NPORTS-1:0][PW-1:0]     ptr_q, ptr_d;
  logic [DROP_W-1:0]             drop_count_q, drop_count_d;
  logic [DROP_W:0]               drop_sum;
  int                            ndrop;

  // rx_ack reflects only registered fullness, held low while in reset.
  assign rx_ack     = ~full & {NPORTS{reset}};
  assign tx_req     = tx_req_q;
  assign tx_data    = tx_data_q;
  assign drop_count = drop_count_q;

  for (genvar i = 0; i < NPORTS; i++) begin : g_in
    assign dest[i] = table_data[i*DIR_W +: DIR_W];
    assign push[i] = rx_req[i] & rx_ack[i];
    assign drop[i] = ~empty[i] & (dest[i] >= NP_DIR);
    assign table_addr[i*SIZE +: SIZE] = empty[i] ? '0 : head[i];

    router_fifo_p #(
      .SIZE  (SIZE),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[i]),
      .wdata (rx_data[i*SIZE +: SIZE]),
      .pop   (pop[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  for (genvar o = 0; o < NPORTS; o++) begin : g_arb
    logic              free;
    logic              vld;
    logic [PW-1:0]     idx;
    logic [NPORTS-1:0] cand;
    int                c;

    assign free = ~tx_req_q[o] | tx_ack[o];

    always_comb begin
      vld  = 1'b0;
      idx  = '0;
      c    = 0;
      cand = '0;
      for (int i = 0; i < NPORTS; i++) begin
        cand[i] = ~empty[i] && (dest[i] == DIR_W'(o));
      end
      for (int k = 0; k < NPORTS; k++) begin
        c = (int'(ptr_q[o]) + k) % NPORTS;
        if (free && !vld && cand[c]) begin
          vld = 1'b1;
          idx = PW'(c);
        end
      end
    end

    assign gnt_vld[o] = vld;
    assign gnt_idx[o] = idx;
  end

  // An input targets one output, so at most one grant or a drop pops it.
  always_comb begin
    pop = drop;
    for (int i = 0; i < NPORTS; i++) begin
      for (int o = 0; o < NPORTS; o++) begin
        if (gnt_vld[o] && gnt_idx[o] == PW'(i)) pop[i] = 1'b1;
      end
    end
  end

  always_comb begin
    tx_req_d  = tx_req_q;
    tx_data_d = tx_data_q;
    ptr_d     = ptr_q;
    for (int o = 0; o < NPORTS; o++) begin
      if (gnt_vld[o]) begin
        tx_req_d[o] = 1'b1;
        ptr_d[o]    = PW'(rr_next(int'(gnt_idx[o]), NPORTS));
        for (int i = 0; i < NPORTS; i++) begin
          if (gnt_idx[o] == PW'(i)) tx_data_d[o] = head[i];
        end
      end else if (tx_ack[o]) begin
        tx_req_d[o] = 1'b0;
      end
    end
  end

  always_comb begin
    ndrop = 0;
    for (int i = 0; i < NPORTS; i++) ndrop = ndrop + (drop[i] ? 1 : 0);
    drop_sum     = {1'b0, drop_count_q} + (DROP_W+1)'(ndrop);
    drop_count_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_req_q     <= '0;
      tx_data_q    <= '0;
      ptr_q        <= '0;
      drop_count_q <= '0;
    end else begin
      tx_req_q     <= tx_req_d;
      tx_data_q    <= tx_data_d;
      ptr_q        <= ptr_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule

// File: tb/tb_router_vc_rr.sv
// Directed bench for router_vc_rr: expected flits are queued per output at
// stimulus time and a negedge monitor pops them on every tx handshake.
module tb_router_vc_rr;

  localparam int NP = 5;
  localparam int SZ = 8;
  localparam int DW = 3;

  logic             clk;
  logic             reset;
  logic [NP-1:0]    rx_req, rx_ack, tx_req, tx_ack;
  logic [NP*SZ-1:0] rx_data, tx_data, table_addr;
  logic [NP*DW-1:0] table_data;
  logic [15:0]      drop_count;

  logic [SZ-1:0] exp_q [NP][$];
  int n_checks = 0;
  int n_fail   = 0;

  router_vc_rr #(
    .ID (0), .NPORTS (NP), .SIZE (SZ), .DEPTH (4), .DIR_W (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_req     (rx_req),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .tx_req     (tx_req),
    .tx_ack     (tx_ack),
    .tx_data    (tx_data),
    .table_addr (table_addr),
    .table_data (table_data),
    .drop_count (drop_count)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Routing table model: destination is flit bits [6:4]; 8'h5A is unroutable.
  function automatic logic [DW-1:0] route_of(input logic [SZ-1:0] f);
    if (f == 8'h5A) return 3'd7;
    return f[6:4];
  endfunction

  always_comb begin
    table_data = '0;
    for (int i = 0; i < NP; i++) table_data[i*DW +: DW] = route_of(table_addr[i*SZ +: SZ]);
  end

  // Driver tasks
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic push_vec(input logic [NP-1:0] mask, input logic [NP*SZ-1:0] data);
    logic [NP-1:0] pend;
    logic [NP-1:0] acc;
    int cyc;
    pend    = mask;
    rx_data = data;
    rx_req  = mask;
    cyc     = 0;
    while (pend != '0 && cyc < 50) begin
      @(negedge clk);
      acc = rx_ack & pend;
      @(posedge clk); #1;
      pend   = pend & ~acc;
      rx_req = pend;
      cyc++;
    end
    if (pend != '0) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: pending mask %0h, required 0", pend);
      rx_req = '0;
    end
  endtask

  task automatic expect_flit(input int o, input logic [SZ-1:0] d);
    exp_q[o].push_back(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      for (int o = 0; o < NP; o++) begin
        if (tx_req[o] && tx_ack[o]) begin
          n_checks++;
          if (exp_q[o].size() == 0) begin
            n_fail++;
            $display("FAIL tx_unexpected port %0d: got %0h, required no flit", o, tx_data[o*SZ +: SZ]);
          end else begin
            logic [SZ-1:0] e;
            e = exp_q[o].pop_front();
            if (tx_data[o*SZ +: SZ] !== e) begin
              n_fail++;
              $display("FAIL tx_data port %0d: got %0h, required %0h", o, tx_data[o*SZ +: SZ], e);
            end
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset   = 1'b0;
    rx_req  = '0;
    rx_data = '0;
    tx_ack  = '1;
    idle(3);
    check("rst_tx_req", 32'(tx_req), 32'h0);
    check("rst_tx_data", tx_data[31:0], 32'h0);
    check("rst_rx_ack", 32'(rx_ack), 32'h0);
    check("rst_drop_count", 32'(drop_count), 32'h0);
    reset = 1'b1;
    idle(1);
    check("post_rst_rx_ack", 32'(rx_ack), 32'h1F);

    // Single flit, input 4 -> output 2, one edge of latency
    expect_flit(2, 8'h23);
    push_vec(5'b10000, {8'h23, 8'h00, 8'h00, 8'h00, 8'h00});
    idle(1);
    check("lat_tx_req", 32'(tx_req), 32'h04);
    check("lat_tx_data2", 32'(tx_data[2*SZ +: SZ]), 32'h23);
    idle(4);

    // Contention on output 4: order 0,1,3 then from ptr=4 -> 0,3 then 4,0,3
    expect_flit(4, 8'h40); expect_flit(4, 8'h41); expect_flit(4, 8'h43);
    push_vec(5'b01011, {8'h00, 8'h43, 8'h00, 8'h41, 8'h40});
    idle(6);
    expect_flit(4, 8'h44); expect_flit(4, 8'h47);
    push_vec(5'b01001, {8'h00, 8'h47, 8'h00, 8'h00, 8'h44});
    idle(5);
    expect_flit(4, 8'h4C); expect_flit(4, 8'h48); expect_flit(4, 8'h4B);
    push_vec(5'b11001, {8'h4C, 8'h4B, 8'h00, 8'h00, 8'h48});
    idle(6);

    // Backpressure: 5 flits into input 2 toward stalled output 1
    tx_ack[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      logic [SZ-1:0] f;
      f = 8'h10 + 8'(k);
      expect_flit(1, f);
      push_vec(5'b00100, {16'h0, f, 16'h0});
    end
    idle(1);
    check("bp_rx_ack2", 32'(rx_ack[2]), 32'h0);
    check("bp_tx_req1", 32'(tx_req[1]), 32'h1);
    check("bp_tx_data1", 32'(tx_data[1*SZ +: SZ]), 32'h10);
    tx_ack = '1;
    idle(8);
    check("bp_rx_ack_back", 32'(rx_ack), 32'h1F);
    check("bp_tx_req_idle", 32'(tx_req), 32'h0);

    // Unroutable flit, then saturation of the drop counter
    push_vec(5'b00001, {32'h0, 8'h5A});
    idle(3);
    check("drop_one", 32'(drop_count), 32'h1);
    rx_data = {NP{8'h5A}};
    rx_req  = '1;
    idle(14000);
    rx_req = '0;
    idle(5);
    check("drop_saturate", 32'(drop_count), 32'hFFFF);

    // Parallel forwarding: inputs 0..3 to outputs 1,2,3,0
    expect_flit(1, 8'h15); expect_flit(2, 8'h26);
    expect_flit(3, 8'h37); expect_flit(0, 8'h08);
    push_vec(5'b01111, {8'h00, 8'h08, 8'h37, 8'h26, 8'h15});
    idle(1);
    check("par_tx_req", 32'(tx_req), 32'h0F);
    idle(4);

    // Reset in mid-transfer discards everything
    tx_ack[0] = 1'b0;
    for (int k = 1; k <= 4; k++) push_vec(5'b00010, {24'h0, 8'(k), 8'h00});
    idle(2);
    check("pre_rst_tx_req", 32'(tx_req), 32'h01);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_tx_req", 32'(tx_req), 32'h0);
    check("mid_rst_rx_ack", 32'(rx_ack), 32'h0);
    check("mid_rst_drop", 32'(drop_count), 32'h0);
    idle(2);
    reset  = 1'b1;
    tx_ack = '1;
    idle(10);
    check("after_rst_rx_ack", 32'(rx_ack), 32'h1F);
    check("after_rst_tx_req", 32'(tx_req), 32'h0);

    for (int o = 0; o < NP; o++) check($sformatf("queue_empty_%0d", o), 32'(exp_q[o].size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_vc_rr.md
Name: router_vc_rr

Overview:
- Next-generation mesh router: NPORTS input ports, each with its own DEPTH-entry FIFO, replacing the single shared FIFO.
- A per-input route lookup picks the output port for each head flit. A per-output round-robin arbiter lets up to NPORTS flits move through the router per cycle.
- Sits between the link transceivers of a tile and the mesh. It keeps the req/ack link style, adds per-port backpressure and a drop counter for unroutable flits.

Parameters:
- ID, -1, router id, used only in simulation $display.
- NPORTS, 5, port count. Ports 0 north, 1 south, 2 east, 3 west, 4 local; indices above 4 are extra local ports.
- SIZE, 8, flit width in bits.
- DEPTH, 4, entries per input FIFO; power of two, at least 2.
- DIR_W, 3, width of a routing-table result; must satisfy 2^DIR_W > NPORTS.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_req  in  NPORTS  per-input flit valid.
- rx_ack  out  NPORTS  per-input accept.
- rx_data  in  NPORTS*SIZE  input flits; port i occupies bits [SIZE*i+SIZE-1 : SIZE*i].
- tx_req  out  NPORTS  per-output flit valid.
- tx_ack  in  NPORTS  per-output accept from downstream.
- tx_data  out  NPORTS*SIZE  output flits, same packing as rx_data.
- table_addr  out  NPORTS*SIZE  head flit of each input FIFO, driven to the external routing table.
- table_data  in  NPORTS*DIR_W  combinational table result per input: the output port index.
- drop_count  out  16  count of flits discarded as unroutable; saturates at 16'hFFFF.

Behaviour:
- Reset (reset=0, asynchronous):
  - All FIFOs empty; tx_req=0; tx_data=0; drop_count=0.
  - All round-robin pointers = 0.
  - rx_ack=0 while reset is asserted.
  - Asserting reset mid-transfer discards every buffered and in-flight flit.
- Link handshake, both directions:
  - A transfer occurs on a rising edge where req=1 and ack=1.
  - The sender holds req and data stable until it sees ack.
- Input side:
  - rx_ack[i] = ~full[i], combinational from registered state; it does not depend on rx_req.
  - On rx_req[i] & rx_ack[i], rx_data slice i is written to FIFO i.
  - A full FIFO does not accept a flit even if a pop happens in the same cycle (no pass-through).
- Route lookup:
  - table_addr slice i = head of FIFO i (0 when empty). The table result is used in the same cycle.
  - A valid head targets output d = table_data slice i.
  - If d >= NPORTS, the head is popped that cycle, not forwarded, and drop_count increments.
- Output stage: each output o has a one-flit register (tx_req[o], tx_data[o]).
  - The register is free when tx_req[o]=0 or tx_ack[o]=1.
  - When free, the arbiter for o grants among inputs whose valid head targets o. It searches round-robin starting at ptr[o].
  - On a grant to input g: the flit loads into the register, tx_req[o]=1, FIFO g pops, and ptr[o] = (g+1) mod NPORTS.
  - With no candidate, ptr[o] is unchanged and tx_req[o] is cleared if the flit was accepted.
  - Back-to-back flits at full throughput: with tx_ack held at 1, one flit per cycle per output.
- Conflict freedom and U-turns:
  - Each input targets exactly one output per cycle, so it is granted by at most one arbiter and pops at most once per cycle.
  - U-turns (output == input) are legal.
- Latency:
  - rx handshake at edge k into an empty FIFO with the output free gives tx_req=1 and valid tx_data after edge k+1.
- FIFO pointers:
  - log2(DEPTH)+1 bits; wrap by natural overflow.
  - full when the MSBs differ and the LSBs are equal; empty when the pointers are equal.
- Simultaneous push and pop on a non-full FIFO: both take effect and the count is unchanged.
- Simulation only: $display on every push, forward and drop, tagged with ID and port number.

Decomposition:
- Shared constants header, extending the 2D one:
  - port index macros PORT_N/S/E/W/L;
  - default SIZE;
  - DIR_W;
  - the drop-counter width.
- Sub-module router_fifo_p: parameterised SIZE/DEPTH synchronous FIFO with async active-low reset, full/empty/head outputs.
  - Instantiated NPORTS times in a generate loop.
- The arbiter is a generate block inside the top level; it is small enough that it does not need its own module.

Test Plan:
- Single flit 8'h23 on input 4, table returns 2 -> tx_req[2]=1 with tx_data slice 2 = 8'h23 one edge after the rx handshake; no other tx_req asserts.
- Inputs 0, 1, 3 all target output 4, tx_ack[4] held at 1 -> grants in order 0, 1, 3 on consecutive cycles; the next contention round from ptr=4 grants 0 first.
- Hold tx_ack[1]=0 and send 5 flits into input 2 targeting 1 (DEPTH=4) -> 1 flit in the output register, 4 buffered, rx_ack[2]=0. Raise tx_ack -> all 5 exit in order, rx_ack[2] returns to 1.
- Table returns 7 for flit 8'h5A -> flit not forwarded, drop_count=1. Force 65536 drops -> drop_count stays at 16'hFFFF.
- Inputs 0 to 3 each target a distinct output simultaneously -> four tx_req assert on the same edge, showing parallel forwarding.
- Assert reset while 3 flits are buffered and tx_req[0]=1 -> tx_req=0, rx_ack=0 and drop_count=0 immediately. After release, rx_ack=all ones and no stale flit appears.
